// File: rtl/airi5c_jtag_tap_ovs_pkg.sv
// Shared JTAG DTM definitions: TAP state encodings, IR opcodes, DMI constants and width rule.
// Build option JTAG_TAP_GLITCH_FILTER_EN is consumed by airi5c_jtag_edge_sync.
package airi5c_jtag_tap_ovs_pkg;

    // IEEE 1149.1 TAP controller states, conventional 4-bit encoding
    typedef enum logic [3:0] {
        TAP_EXIT2_DR         = 4'h0,
        TAP_EXIT1_DR         = 4'h1,
        TAP_SHIFT_DR         = 4'h2,
        TAP_PAUSE_DR         = 4'h3,
        TAP_SELECT_IR        = 4'h4,
        TAP_UPDATE_DR        = 4'h5,
        TAP_CAPTURE_DR       = 4'h6,
        TAP_SELECT_DR        = 4'h7,
        TAP_EXIT2_IR         = 4'h8,
        TAP_EXIT1_IR         = 4'h9,
        TAP_SHIFT_IR         = 4'hA,
        TAP_PAUSE_IR         = 4'hB,
        TAP_RUN_TEST_IDLE    = 4'hC,
        TAP_UPDATE_IR        = 4'hD,
        TAP_CAPTURE_IR       = 4'hE,
        TAP_TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    localparam logic [4:0] IR_IDCODE  = 5'h01;
    localparam logic [4:0] IR_DTMCS   = 5'h10;
    localparam logic [4:0] IR_DMI     = 5'h11;
    localparam logic [4:0] IR_BYPASS  = 5'h1F;
    localparam logic [4:0] IR_CAPTURE = 5'b00001;

    localparam int         DMI_DATA_W   = 32;
    localparam int         DMI_OP_W     = 2;
    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    function automatic int dmi_width(input int abits);
        return abits + DMI_DATA_W + DMI_OP_W;
    endfunction

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        case (s)
            TAP_TEST_LOGIC_RESET: n = tms ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
            TAP_RUN_TEST_IDLE:    n = tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
            TAP_SELECT_DR:        n = tms ? TAP_SELECT_IR        : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR:       n = tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
            TAP_SHIFT_DR:         n = tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
            TAP_EXIT1_DR:         n = tms ? TAP_UPDATE_DR        : TAP_PAUSE_DR;
            TAP_PAUSE_DR:         n = tms ? TAP_EXIT2_DR         : TAP_PAUSE_DR;
            TAP_EXIT2_DR:         n = tms ? TAP_UPDATE_DR        : TAP_SHIFT_DR;
            TAP_UPDATE_DR:        n = tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
            TAP_SELECT_IR:        n = tms ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR:       n = tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
            TAP_SHIFT_IR:         n = tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
            TAP_EXIT1_IR:         n = tms ? TAP_UPDATE_IR        : TAP_PAUSE_IR;
            TAP_PAUSE_IR:         n = tms ? TAP_EXIT2_IR         : TAP_PAUSE_IR;
            TAP_EXIT2_IR:         n = tms ? TAP_UPDATE_IR        : TAP_SHIFT_IR;
            TAP_UPDATE_IR:        n = tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
            default:              n = TAP_TEST_LOGIC_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/airi5c_jtag_tap_ovs_edge_sync.sv
// Oversampling synchroniser and tck edge detector for the JTAG pins.
// Define JTAG_TAP_GLITCH_FILTER_EN to require 2 further equal tck samples before an edge counts.
module airi5c_jtag_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tck_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tck_rise_o,
    output logic tck_fall_o,
    output logic tms_o,
    output logic tdi_o
);
    import airi5c_jtag_tap_ovs_pkg::*;

    logic [1:0] tck_sync_q;
    logic [1:0] tms_sync_q;
    logic [1:0] tdi_sync_q;
    logic       tck_lvl_q;
    logic       tck_lvl_d;
    logic [1:0] hold_q;
    logic [1:0] hold_d;
    logic       tck_stable_s;
    logic       tck_edge_s;

    // Two-flop synchronisers on all three pins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tck_sync_q <= 2'b00;
            tms_sync_q <= 2'b00;
            tdi_sync_q <= 2'b00;
        end else begin
            tck_sync_q <= {tck_sync_q[0], tck_i};
            tms_sync_q <= {tms_sync_q[0], tms_i};
            tdi_sync_q <= {tdi_sync_q[0], tdi_i};
        end
    end

`ifdef JTAG_TAP_GLITCH_FILTER_EN
    logic [1:0] tck_hist_q;
    logic [1:0] tms_hist_q;
    logic [1:0] tdi_hist_q;

    // History stage: tms/tdi are delayed alongside tck so they stay aligned with the filtered edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tck_hist_q <= 2'b00;
            tms_hist_q <= 2'b00;
            tdi_hist_q <= 2'b00;
        end else begin
            tck_hist_q <= {tck_hist_q[0], tck_sync_q[1]};
            tms_hist_q <= {tms_hist_q[0], tms_sync_q[1]};
            tdi_hist_q <= {tdi_hist_q[0], tdi_sync_q[1]};
        end
    end

    assign tck_stable_s = (tck_sync_q[1] == tck_hist_q[0]) && (tck_hist_q[0] == tck_hist_q[1]);
    assign tms_o        = tms_hist_q[1];
    assign tdi_o        = tdi_hist_q[1];
`else
    assign tck_stable_s = 1'b1;
    assign tms_o        = tms_sync_q[1];
    assign tdi_o        = tdi_sync_q[1];
`endif

    // Edge detection against the last accepted level; hold-off blanks the next two cycles
    always_comb begin
        tck_edge_s = 1'b0;
        tck_lvl_d  = tck_lvl_q;
        hold_d     = hold_q;
        if (tck_stable_s && (tck_sync_q[1] != tck_lvl_q) && (hold_q == 2'd0)) begin
            tck_edge_s = 1'b1;
            tck_lvl_d  = tck_sync_q[1];
            hold_d     = 2'd2;
        end else if (hold_q != 2'd0) begin
            hold_d = hold_q - 2'd1;
        end else begin
            hold_d = hold_q;
        end
    end

    // Accepted tck level and hold-off counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tck_lvl_q <= 1'b0;
            hold_q    <= 2'd0;
        end else begin
            tck_lvl_q <= tck_lvl_d;
            hold_q    <= hold_d;
        end
    end

    assign tck_rise_o = tck_edge_s & tck_sync_q[1];
    assign tck_fall_o = tck_edge_s & ~tck_sync_q[1];

endmodule

// File: rtl/airi5c_jtag_tap_ovs.sv
// Oversampled JTAG TAP / DTM front end: TAP FSM, IR, IDCODE/DTMCS/DMI/BYPASS data registers.
// Build option JTAG_TAP_GLITCH_FILTER_EN selects the filtered tck edge detector.
module airi5c_jtag_tap_ovs
    import airi5c_jtag_tap_ovs_pkg::*;
#(
    parameter logic [31:0] IDCODE = 32'h1000_0001,
    parameter int          ABITS  = 7
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              tck,
    input  logic              tms,
    input  logic              tdi,
    output logic              tdo,
    input  logic [ABITS+33:0] dmi_capture,
    output logic              dmi_update,
    output logic [ABITS+33:0] dmi_data,
    input  logic [31:0]       dtmcs_capture,
    output logic              dtmcs_update,
    output logic [31:0]       dtmcs_data,
    output logic [3:0]        tap_state
);
    localparam int W = dmi_width(ABITS);

    logic         tck_rise_s;
    logic         tck_fall_s;
    logic         tms_s;
    logic         tdi_s;

    tap_state_e   tap_state_q;
    tap_state_e   tap_state_d;
    logic [4:0]   ir_q;
    logic [4:0]   ir_d;
    logic [4:0]   ir_sr_q;
    logic [4:0]   ir_sr_d;
    logic [W-1:0] dr_sr_q;
    logic [W-1:0] dr_sr_d;
    logic         tdo_q;
    logic         tdo_d;
    logic         dmi_update_q;
    logic         dmi_update_d;
    logic [W-1:0] dmi_data_q;
    logic [W-1:0] dmi_data_d;
    logic         dtmcs_update_q;
    logic         dtmcs_update_d;
    logic [31:0]  dtmcs_data_q;
    logic [31:0]  dtmcs_data_d;

    airi5c_jtag_edge_sync u_edge_sync (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .tck_i      (tck),
        .tms_i      (tms),
        .tdi_i      (tdi),
        .tck_rise_o (tck_rise_s),
        .tck_fall_o (tck_fall_s),
        .tms_o      (tms_s),
        .tdi_o      (tdi_s)
    );

    // TAP next state and register actions, evaluated once per accepted tck edge
    always_comb begin
        tap_state_d    = tap_state_q;
        ir_d           = ir_q;
        ir_sr_d        = ir_sr_q;
        dr_sr_d        = dr_sr_q;
        tdo_d          = tdo_q;
        dmi_update_d   = 1'b0;
        dmi_data_d     = dmi_data_q;
        dtmcs_update_d = 1'b0;
        dtmcs_data_d   = dtmcs_data_q;

        if (tck_rise_s) begin
            tap_state_d = tap_next(tap_state_q, tms_s);
            case (tap_state_q)
                TAP_TEST_LOGIC_RESET, TAP_SELECT_IR: begin
                    if (tms_s) begin
                        ir_d = IR_IDCODE;
                    end else begin
                        ir_d = ir_q;
                    end
                end
                TAP_CAPTURE_DR: begin
                    case (ir_q)
                        IR_IDCODE: dr_sr_d = {{(W-32){1'b0}}, IDCODE};
                        IR_DTMCS:  dr_sr_d = {{(W-32){1'b0}}, dtmcs_capture};
                        IR_DMI:    dr_sr_d = dmi_capture;
                        default:   dr_sr_d = {W{1'b0}};
                    endcase
                end
                TAP_SHIFT_DR: begin
                    // tdi enters at the MSB of whichever register length is selected
                    case (ir_q)
                        IR_IDCODE, IR_DTMCS: dr_sr_d = {{(W-32){1'b0}}, tdi_s, dr_sr_q[31:1]};
                        IR_DMI:              dr_sr_d = {tdi_s, dr_sr_q[W-1:1]};
                        default:             dr_sr_d = {{(W-1){1'b0}}, tdi_s};
                    endcase
                end
                TAP_EXIT1_DR, TAP_EXIT2_DR: begin
                    if (tms_s) begin
                        case (ir_q)
                            IR_DTMCS: begin
                                dtmcs_data_d   = dr_sr_q[31:0];
                                dtmcs_update_d = 1'b1;
                            end
                            IR_DMI: begin
                                dmi_data_d   = dr_sr_q;
                                dmi_update_d = 1'b1;
                            end
                            default: begin
                                dmi_update_d   = 1'b0;
                                dtmcs_update_d = 1'b0;
                            end
                        endcase
                    end else begin
                        dmi_update_d   = 1'b0;
                        dtmcs_update_d = 1'b0;
                    end
                end
                TAP_CAPTURE_IR: ir_sr_d = IR_CAPTURE;
                TAP_SHIFT_IR:   ir_sr_d = {tdi_s, ir_sr_q[4:1]};
                TAP_EXIT1_IR, TAP_EXIT2_IR: begin
                    if (tms_s) begin
                        ir_d = ir_sr_q;
                    end else begin
                        ir_d = ir_q;
                    end
                end
                default: tap_state_d = tap_next(tap_state_q, tms_s);
            endcase
        end else if (tck_fall_s) begin
            case (tap_state_q)
                TAP_SHIFT_DR: tdo_d = dr_sr_q[0];
                TAP_SHIFT_IR: tdo_d = ir_sr_q[0];
                default:      tdo_d = tdo_q;
            endcase
        end else begin
            tdo_d = tdo_q;
        end
    end

    // State and data registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tap_state_q    <= TAP_TEST_LOGIC_RESET;
            ir_q           <= IR_IDCODE;
            ir_sr_q        <= 5'h00;
            dr_sr_q        <= {W{1'b0}};
            tdo_q          <= 1'b0;
            dmi_update_q   <= 1'b0;
            dmi_data_q     <= {W{1'b0}};
            dtmcs_update_q <= 1'b0;
            dtmcs_data_q   <= 32'h0000_0000;
        end else begin
            tap_state_q    <= tap_state_d;
            ir_q           <= ir_d;
            ir_sr_q        <= ir_sr_d;
            dr_sr_q        <= dr_sr_d;
            tdo_q          <= tdo_d;
            dmi_update_q   <= dmi_update_d;
            dmi_data_q     <= dmi_data_d;
            dtmcs_update_q <= dtmcs_update_d;
            dtmcs_data_q   <= dtmcs_data_d;
        end
    end

    assign tdo          = tdo_q;
    assign dmi_update   = dmi_update_q;
    assign dmi_data     = dmi_data_q;
    assign dtmcs_update = dtmcs_update_q;
    assign dtmcs_data   = dtmcs_data_q;
    assign tap_state    = tap_state_q;

endmodule

// File: doc/airi5c_jtag_tap_ovs.md
AIRI5C_JTAG_TAP_OVS -- requirements
Module: airi5c_jtag_tap_ovs

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1000_0001, value shifted out for the IDCODE instruction.
REQ-002 SHALL have parameter ABITS, default 7, DMI address width; DMI register width W = ABITS+34.
REQ-003 SHALL have ports: CLK  in  1  system clock (only clock; all flops on its rising edge).
REQ-004 SHALL have ports: RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: tck, tms, tdi  in  1 each  JTAG pins, asynchronous to CLK; tdo  out  1  JTAG data out.
REQ-006 SHALL have ports: dmi_capture  in  W  data loaded into the DMI register at Capture-DR.
REQ-007 SHALL have ports: dmi_update  out  1  one-CLK pulse at Update-DR with DMI selected; dmi_data  out  W  DMI register value, valid with the pulse.
REQ-008 SHALL have ports: dtmcs_capture  in  32  DTMCS read value; dtmcs_update  out  1  pulse; dtmcs_data  out  32  written value.
REQ-009 SHALL have ports: tap_state  out  4  current TAP state encoding, for debug.

Function
REQ-010 SHALL synchronise tck, tms and tdi through two flops each; tck rise/fall SHALL be detected from the last two synchronised samples.
REQ-011 SHALL advance the TAP FSM once per detected tck rise, using tms sampled at that rise; states: Test-Logic-Reset, Run-Test/Idle, Select-DR, Capture-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Update-DR, and the IR equivalents (16 total, IEEE 1149.1 transitions).
REQ-012 SHALL keep a 5-bit IR: Test-Logic-Reset loads 5'h01 (IDCODE); Capture-IR loads 5'b00001; Shift-IR shifts tdi in at the MSB; Update-IR copies the shift register to the active IR.
REQ-013 SHALL decode IR: 5'h01 IDCODE (32 bit), 5'h10 DTMCS (32 bit), 5'h11 DMI (W bit); any other value, including 5'h1F, selects BYPASS (1 bit, captures 0).
REQ-014 SHALL load the selected DR at Capture-DR, shift LSB-first at Shift-DR with tdi entering the MSB, and act at Update-DR.
REQ-015 SHALL drive tdo from the LSB of the active shift register, updated on the detected tck fall only in Shift-DR/Shift-IR; tdo SHALL hold its value otherwise.
REQ-016 SHALL assert dmi_update or dtmcs_update for exactly one CLK, in the cycle after the rise that enters Update-DR; dmi_data/dtmcs_data SHALL hold until the next update.
REQ-017 SHALL ignore tck edges closer than 3 CLK apart (tck frequency limit CLK/6); behaviour beyond that limit is undefined.
REQ-018 SHALL reach Test-Logic-Reset after 5 consecutive rises with tms=1 from any state.
REQ-019 Simultaneous events: a tck rise and fall SHALL never be detected in the same CLK; an update pulse SHALL NOT be generated in the same CLK as RESET.

Reset
REQ-020 RESET SHALL asynchronously set: TAP state Test-Logic-Reset, IR 5'h01, shift registers 0, synchronisers 0, tdo 0, update pulses 0, dmi_data 0, dtmcs_data 0.
REQ-021 RESET mid-shift SHALL abort the scan with no update pulse; the next scan starts from Test-Logic-Reset.

Configuration
REQ-022 With JTAG_TAP_GLITCH_FILTER_EN defined, a tck level SHALL count only after 2 further equal synchronised samples (edge latency 4 CLK, limit CLK/10); without it, edge latency SHALL be 2 CLK per REQ-010.

Structure
REQ-023 TAP state encodings, IR opcodes and the DMI width rule SHALL live in a shared package header alongside the existing DMI constants.
REQ-024 The synchroniser/edge detector (and optional glitch filter) SHALL be a sub-module airi5c_jtag_edge_sync; the FSM and registers stay in the top.

Verification
REQ-025 RESET, then 5 tck with tms=1, then shift 32 DR bits -> tdo yields 32'h1000_0001 LSB first.
REQ-026 Shift IR 5'h1F, DR pattern 1,0,1,1 -> tdo returns 0,1,0,1 (1-bit delay, leading 0).
REQ-027 IR 5'h11, dmi_capture=41'h1_2345_6789_A, shift in 41'h0_DEAD_BEEF_2 -> tdo streams capture value, dmi_update one pulse, dmi_data=41'h0_DEAD_BEEF_2.
REQ-028 Shift IR 5'h10, then Exit1-IR, Pause-IR, Exit2-IR, Update-IR -> DTMCS selected; IR capture shifts out 5'b00001.
REQ-029 Assert RESET during Shift-DR of a DMI scan -> no dmi_update, tap_state = Test-Logic-Reset, IR = 5'h01.
REQ-030 With JTAG_TAP_GLITCH_FILTER_EN, 1-CLK tck high glitches during Shift-DR -> no state change, no shift.
